// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS32 unified-memory arbiter.
package mips_mem_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  // HLT opcode word of the core; kept here so stage logic and the arbiter
  // agree on what a halting fetch looks like.
  localparam logic [31:0] INSTR_HALT = 32'hfc000000;

  // Arbiter FSM encoding (also visible on dbg_state).
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Which stage owns the transaction currently in flight.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/mips_arb_pick.sv
// Priority picker: data stage normally wins, but instruction fetch gets a
// turn once the data stage has won MAX_STREAK times in a row while fetch
// waited. Also produces the next value of the streak counter.
module mips_arb_pick #(
  parameter int MAX_STREAK = 4,
  parameter int SW         = 3
) (
  input  logic          idle,
  input  logic          halted,
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [SW-1:0] streak,
  output logic          if_win,
  output logic          dm_win,
  output logic [SW-1:0] streak_nxt
);

  logic if_turn;

  // Winner selection and streak bookkeeping; grants only exist while idle.
  always_comb begin
    if_turn    = (streak == SW'(MAX_STREAK));
    if_win     = idle & if_req & ~halted & (~dm_req | if_turn);
    dm_win     = idle & dm_req & ~if_win;
    streak_nxt = streak;
    if (!if_req || if_win) begin
      streak_nxt = '0;
    end else if (dm_win && !if_turn) begin
      streak_nxt = streak + SW'(1);
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (read-only) and the
// data stage (load/store). One transaction in flight, IDLE->ISSUE->WAIT->DONE.
//
// Handshake: a requester raises <stage>_req and holds addr/we/wdata stable
// until <stage>_gnt is seen high in the same cycle (gnt is combinational and
// only possible in IDLE); the transfer is accepted on that clock edge. The
// result comes back as a single-cycle <stage>_rvalid with <stage>_rdata.
// Toward memory, mem_req is a one-cycle strobe and mem_rvalid is accepted
// only in WAIT; anything arriving at another time is a stale response.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          bus_err,
  output logic [1:0]    dbg_state
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  owner_e        owner;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;
  logic [TW-1:0] timer;
  logic          idle;
  logic          if_win;
  logic          dm_win;
  logic          resp;
  logic          timed_out;

  // Gated with rst_n so nothing is granted while reset is held.
  assign idle = rst_n & (state == S_IDLE);

  mips_arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_pick (
    .idle       (idle),
    .halted     (halted),
    .if_req     (if_req),
    .dm_req     (dm_req),
    .streak     (streak),
    .if_win     (if_win),
    .dm_win     (dm_win),
    .streak_nxt (streak_nxt)
  );

  // Grant, stall, strobe and response routing outputs.
  always_comb begin
    resp      = (state == S_WAIT) & mem_rvalid;
    timed_out = (state == S_WAIT) & ~mem_rvalid & (timer == TW'(TIMEOUT));
    if_gnt    = if_win;
    dm_gnt    = dm_win;
    stall_if  = rst_n & if_req & ~if_win;
    stall_dm  = rst_n & dm_req & ~dm_win;
    mem_req   = (state == S_ISSUE);
    bus_err   = timed_out;
    if_rvalid = (resp | timed_out) & (owner == OWN_IF);
    dm_rvalid = (resp | timed_out) & (owner == OWN_DM);
    if_rdata  = (resp && owner == OWN_IF) ? mem_rdata : '0;
    dm_rdata  = (resp && owner == OWN_DM && !mem_we) ? mem_rdata : '0;
    dbg_state = state;
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (if_win || dm_win) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (resp || timed_out) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, owner, latched request fields, streak counter and WAIT timer.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= OWN_NONE;
      streak    <= '0;
      timer     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      if (if_win || dm_win) begin
        owner     <= if_win ? OWN_IF : OWN_DM;
        mem_we    <= dm_win & dm_we;
        mem_addr  <= if_win ? if_addr : dm_addr;
        mem_wdata <= dm_win ? dm_wdata : '0;
      end else if (state == S_DONE) begin
        owner <= OWN_NONE;
      end
      if (state == S_ISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT && !resp && !timed_out) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: reset, single fetch timing, DM/IF
// fairness streak, store/load routing, halted blocking, timeout and
// reset in the middle of a transaction.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int AW         = 10;
  localparam int DW         = 32;
  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 15;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          halted = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_if;
  logic          stall_dm;
  logic          bus_err;
  logic [1:0]    dbg_state;

  int   n_vec = 0;
  int   n_err = 0;
  logic auto_mem = 1'b0;
  logic pend = 1'b0;

  // Clock
  always #5 clk1 = ~clk1;

  mips_mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; returns 3ns after the rising edge. With auto_mem set,
  // memory answers one cycle after each mem_req with data A0000000|addr.
  task automatic cyc();
    @(posedge clk1);
    #2;
    if (auto_mem) begin
      mem_rvalid = pend;
      mem_rdata  = pend ? (32'hA000_0000 | {22'd0, mem_addr}) : 32'h0;
      pend       = 1'b0;
      #1;
      if (mem_req) pend = 1'b1;
    end else begin
      #1;
    end
  endtask

  // Look for a grant starting with the current cycle; who: 1=IF 2=DM 3=both.
  task automatic wait_gnt(output int who, output int ncyc);
    who  = 0;
    ncyc = 0;
    for (int i = 0; i <= 30 && who == 0; i++) begin
      if (i > 0) cyc();
      #1;
      ncyc = i;
      if (if_gnt && dm_gnt) who = 3;
      else if (if_gnt)      who = 1;
      else if (dm_gnt)      who = 2;
    end
    chk("gnt_seen", 64'(who != 0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int nc;
    int bad;
    int n;
    int exp_seq[10];
    exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    // Reset held with a fetch request and a stray memory response.
    rst_n = 1'b0; if_req = 1'b1; if_addr = 10'd5;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (3) cyc();
    #1;
    chk("rst_ctrl", 64'({if_gnt, dm_gnt, mem_req, if_rvalid, dm_rvalid, bus_err, stall_if, stall_dm}), 64'd0);
    chk("rst_regs", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));

    // Single fetch, memory answers two cycles after mem_req.
    mem_rvalid = 1'b0;
    cyc(); rst_n = 1'b1; #1;
    chk("if_gnt_c0", 64'(if_gnt), 64'd1);
    chk("stall_if_c0", 64'(stall_if), 64'd0);
    chk("mem_req_c0", 64'(mem_req), 64'd0);
    cyc(); if_req = 1'b0; #1;
    chk("mem_req_c1", 64'(mem_req), 64'd1);
    chk("mem_addr_c1", 64'(mem_addr), 64'd5);
    chk("mem_we_c1", 64'(mem_we), 64'd0);
    cyc(); #1;
    chk("mem_req_c2", 64'(mem_req), 64'd0);
    chk("if_rvalid_c2", 64'(if_rvalid), 64'd0);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h0022_2000; #1;
    chk("if_rvalid_c3", 64'(if_rvalid), 64'd1);
    chk("if_rdata_c3", 64'(if_rdata), 64'h0022_2000);
    chk("dm_rvalid_c3", 64'(dm_rvalid), 64'd0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("if_rvalid_c4", 64'(if_rvalid), 64'd0);
    chk("state_c4", 64'(dbg_state), 64'(S_DONE));
    cyc(); #1;
    chk("state_c5", 64'(dbg_state), 64'(S_IDLE));

    // Both stages requesting continuously: DM x4, then IF, streak restarts.
    auto_mem = 1'b1; pend = 1'b0;
    if_req = 1'b1; if_addr = 10'd12;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20;
    for (int k = 0; k < 10; k++) begin
      wait_gnt(who, nc);
      chk($sformatf("arb_who_%0d", k), 64'(who), 64'(exp_seq[k]));
      if (k > 0) chk($sformatf("arb_space_%0d", k), 64'(nc + 1), 64'd4);
      cyc();
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) cyc();

    // Store: registered write fields, store completion carries zero data.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd8; dm_wdata = 32'd10;
    wait_gnt(who, nc);
    chk("st_who", 64'(who), 64'd2);
    cyc(); dm_req = 1'b0; dm_we = 1'b0; #1;
    chk("st_mem_req", 64'(mem_req), 64'd1);
    chk("st_mem_we", 64'(mem_we), 64'd1);
    chk("st_mem_addr", 64'(mem_addr), 64'd8);
    chk("st_mem_wdata", 64'(mem_wdata), 64'd10);
    cyc(); #1;
    chk("st_rvalid", 64'(dm_rvalid), 64'd1);
    chk("st_rdata", 64'(dm_rdata), 64'd0);
    chk("st_if_rvalid", 64'(if_rvalid), 64'd0);
    cyc(); cyc();

    // Load returns memory data to the data stage.
    dm_req = 1'b1; dm_addr = 10'd3;
    wait_gnt(who, nc);
    cyc(); dm_req = 1'b0;
    cyc(); #1;
    chk("ld_rvalid", 64'(dm_rvalid), 64'd1);
    chk("ld_rdata", 64'(dm_rdata), 64'hA000_0003);
    cyc(); cyc();

    // Halted blocks fetch grants; fetch stays stalled.
    halted = 1'b1; if_req = 1'b1; if_addr = 10'd9;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (if_gnt || !stall_if) bad++;
      cyc();
    end
    chk("halt_block", 64'(bad), 64'd0);
    halted = 1'b0; #1;
    chk("unhalt_gnt", 64'(if_gnt), 64'd1);
    // Halt rising mid-fetch does not abort the fetch.
    cyc(); if_req = 1'b0; halted = 1'b1;
    cyc(); #1;
    chk("halt_mid_rvalid", 64'(if_rvalid), 64'd1);
    chk("halt_mid_rdata", 64'(if_rdata), 64'hA000_0009);
    halted = 1'b0;
    cyc(); cyc();

    // Memory never answers: bus error after TIMEOUT idle WAIT cycles.
    auto_mem = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    dm_req = 1'b1; dm_addr = 10'd7;
    wait_gnt(who, nc);
    cyc(); dm_req = 1'b0; #1;
    chk("tmo_issue", 64'(mem_req), 64'd1);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      cyc(); #1;
      if (bus_err) n = i;
    end
    chk("tmo_cycles", 64'(n), 64'(TIMEOUT + 1));
    chk("tmo_rvalid", 64'(dm_rvalid), 64'd1);
    chk("tmo_rdata", 64'(dm_rdata), 64'd0);
    cyc(); mem_rvalid = 1'b1; #1;
    chk("late_rvalid", 64'({dm_rvalid, if_rvalid, bus_err}), 64'd0);
    chk("late_state", 64'(dbg_state), 64'(S_DONE));
    cyc(); #1;
    chk("late_idle", 64'(dbg_state), 64'(S_IDLE));
    chk("late_ignored", 64'({dm_rvalid, if_rvalid}), 64'd0);
    mem_rvalid = 1'b0;

    // Reset in the middle of a fetch.
    if_req = 1'b1; if_addr = 10'd2;
    wait_gnt(who, nc);
    cyc(); if_req = 1'b0; #1;
    chk("mid_issue", 64'(mem_req), 64'd1);
    rst_n = 1'b0; mem_rvalid = 1'b1; #1;
    chk("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
    chk("mid_rst_out", 64'({mem_req, if_rvalid, bus_err, mem_addr}), 64'd0);
    cyc(); rst_n = 1'b1; mem_rvalid = 1'b0;
    cyc(); #1;
    chk("mid_rst_idle", 64'(dbg_state), 64'(S_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
